cache_mem_arbiter: RTL and testbench

Round-robin arbiter that shares the single line-wide memory master port between PORTS per-core cache routing blocks. Each requester presents a registered Avalon-style line request (read/write/waitrequest). The arbiter grants one requester at a time, registers that request onto the memory bus, and holds it until memory drops waitrequest. It sits between the per-core routing blocks and the system interconnect.

---
 rtl/cache_mem_arbiter_pkg.sv | 16 +
 rtl/cache_rr_picker.sv | 37 +++
 rtl/cache_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared cache type definitions plus the memory arbiter's port index and FSM state types.
package cache_mem_arbiter_pkg;

  typedef logic [31:0]  word;
  typedef logic [127:0] line;
  typedef logic [15:0]  line_be;

  // Wide enough to index the largest supported requester count (8).
  typedef logic [2:0] arb_port;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/cache_rr_picker.sv
// Combinational rotate-priority encoder: first active index at or after rr, wrapping modulo PORTS.
module cache_rr_picker #(
  parameter int PORTS = 4
) (
  input  logic [PORTS-1:0]         active,
  input  logic [$clog2(PORTS)-1:0] rr,
  output logic                     valid,
  output logic [$clog2(PORTS)-1:0] winner
);

  localparam int IDX_W = $clog2(PORTS);

  logic [2*PORTS-1:0] doubled;
  logic [PORTS-1:0]   rotated;
  logic [IDX_W-1:0]   offset;
  logic [IDX_W:0]     sum;

  // Rotating the doubled vector puts requester rr at bit 0.
  assign doubled = {active, active};
  assign rotated = PORTS'(doubled >> rr);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    valid  = 1'b0;
    offset = '0;
    for (int j = PORTS - 1; j >= 0; j--) begin
      if (rotated[j]) begin
        valid  = 1'b1;
        offset = IDX_W'(j);
      end
    end
  end

  assign sum    = {1'b0, rr} + {1'b0, offset};
  assign winner = (sum >= (IDX_W + 1)'(PORTS)) ? IDX_W'(sum - (IDX_W + 1)'(PORTS)) : IDX_W'(sum);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory master among PORTS cache routing blocks.
// Define CACHE_ARB_PERF_EN to add per-port grant and wait-cycle counters.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int PORTS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  word    [PORTS-1:0]   in_address,
  input  logic   [PORTS-1:0]   in_read,
  input  logic   [PORTS-1:0]   in_write,
  input  line    [PORTS-1:0]   in_writedata,
  input  line_be [PORTS-1:0]   in_byteenable,
  output logic   [PORTS-1:0]   in_waitrequest,
  output line                  in_readdata,
  input  logic                 mem_waitrequest,
  input  line                  mem_readdata,
  output word                  mem_address,
  output logic                 mem_read,
  output logic                 mem_write,
  output line                  mem_writedata,
  output line_be               mem_byteenable
`ifdef CACHE_ARB_PERF_EN
  ,
  output logic [PORTS-1:0][31:0] perf_grants,
  output logic [PORTS-1:0][31:0] perf_wait_cycles
`endif
);

  localparam int IDX_W = $clog2(PORTS);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] pick_winner;
  logic             pick_valid;
  logic             capture;
  logic             complete;
  logic [PORTS-1:0] active;

  assign active      = in_read | in_write;
  assign in_readdata = mem_readdata;

  cache_rr_picker #(.PORTS(PORTS)) u_picker (
    .active (active),
    .rr     (rr_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    rr_d           = rr_q;
    capture        = 1'b0;
    complete       = 1'b0;
    in_waitrequest = '1;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_BUSY;
          grant_d = pick_winner;
          capture = 1'b1;
        end
      end
      ARB_BUSY: begin
        // Gated by rst_n so requesters see a stall for the whole reset cycle.
        if (rst_n) begin
          in_waitrequest[grant_q] = mem_waitrequest;
        end
        if (!mem_waitrequest) begin
          complete = 1'b1;
          state_d  = ARB_IDLE;
          rr_d     = (grant_q == IDX_W'(PORTS - 1)) ? '0 : grant_q + IDX_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      if (capture) begin
        mem_read  <= in_read[pick_winner];
        mem_write <= in_write[pick_winner];
      end else if (complete) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
      end
    end
  end

  // NOTE: the request datapath is deliberately unreset; it is only meaningful while a strobe is high.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem_address    <= in_address[pick_winner];
      mem_writedata  <= in_writedata[pick_winner];
      mem_byteenable <= in_byteenable[pick_winner];
    end
  end

`ifdef CACHE_ARB_PERF_EN
  // A port is served while it owns the bus or is winning arbitration this cycle.
  logic [PORTS-1:0] served;

  always_comb begin
    served = '0;
    if (state_q == ARB_BUSY) begin
      served[grant_q] = 1'b1;
    end else if (pick_valid) begin
      served[pick_winner] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_grants      <= '0;
      perf_wait_cycles <= '0;
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        if (complete && grant_q == IDX_W'(i)) begin
          perf_grants[i] <= perf_grants[i] + 32'd1;
        end
        if (active[i] && !served[i]) begin
          perf_wait_cycles[i] <= perf_wait_cycles[i] + 32'd1;
        end
      end
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed vector table, round-robin sequence,
// randomized traffic against a transaction-level reference model, and optional perf counters.
module tb_cache_mem_arbiter;
  import cache_mem_arbiter_pkg::*;

  localparam int PORTS = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  word    [PORTS-1:0]   in_address;
  logic   [PORTS-1:0]   in_read;
  logic   [PORTS-1:0]   in_write;
  line    [PORTS-1:0]   in_writedata;
  line_be [PORTS-1:0]   in_byteenable;
  logic   [PORTS-1:0]   in_waitrequest;
  line                  in_readdata;
  logic                 mem_waitrequest;
  line                  mem_readdata;
  word                  mem_address;
  logic                 mem_read;
  logic                 mem_write;
  line                  mem_writedata;
  line_be               mem_byteenable;
`ifdef CACHE_ARB_PERF_EN
  logic [PORTS-1:0][31:0] perf_grants;
  logic [PORTS-1:0][31:0] perf_wait_cycles;
`endif

  cache_mem_arbiter #(.PORTS(PORTS)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_address      (in_address),
    .in_read         (in_read),
    .in_write        (in_write),
    .in_writedata    (in_writedata),
    .in_byteenable   (in_byteenable),
    .in_waitrequest  (in_waitrequest),
    .in_readdata     (in_readdata),
    .mem_waitrequest (mem_waitrequest),
    .mem_readdata    (mem_readdata),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_writedata   (mem_writedata),
    .mem_byteenable  (mem_byteenable)
`ifdef CACHE_ARB_PERF_EN
    ,
    .perf_grants      (perf_grants),
    .perf_wait_cycles (perf_wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Inputs are applied 1 time unit after the edge and outputs compared 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Fixed per-port request fields used by the directed parts.
  word    c_addr  [PORTS] = '{32'h0000_0400, 32'h0000_0810, 32'h0000_1230, 32'h0000_2FF0};
  line_be c_be    [PORTS] = '{16'hFFFF, 16'h000F, 16'h00FF, 16'hF0F0};
  line    c_wdata [PORTS];

  task automatic load_port_constants();
    for (int i = 0; i < PORTS; i++) begin
      in_address[i]    = c_addr[i];
      in_byteenable[i] = c_be[i];
      c_wdata[i]       = {4{32'hC0DE_0000 + 32'(i)}};
      in_writedata[i]  = c_wdata[i];
    end
  endtask

  typedef struct {
    logic             rst_n;
    logic [PORTS-1:0] rd;
    logic [PORTS-1:0] wr;
    logic             mw;
    logic [PORTS-1:0] e_wait;
    logic             e_rd;
    logic             e_wr;
    int               e_port;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [3:0] rd, logic [3:0] wr, logic mw,
                              logic [3:0] ew, logic erd, logic ewr, int ep);
    vec_t v;
    v.rst_n = r; v.rd = rd; v.wr = wr; v.mw = mw;
    v.e_wait = ew; v.e_rd = erd; v.e_wr = ewr; v.e_port = ep;
    return v;
  endfunction

  // Transaction-level reference model state.
  bit     m_busy;
  int     m_owner;
  int     m_rr;
  logic   m_rd, m_wr;
  word    m_addr;
  line    m_wdata;
  line_be m_be;

  function automatic logic [PORTS-1:0] model_wait();
    logic [PORTS-1:0] w;
    w = '1;
    if (m_busy && rst_n) w[m_owner] = mem_waitrequest;
    return w;
  endfunction

  task automatic model_step();
    bit found;
    if (!rst_n) begin
      m_busy = 1'b0; m_rr = 0; m_rd = 1'b0; m_wr = 1'b0;
    end else if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < PORTS; k++) begin
        int p;
        p = (m_rr + k) % PORTS;
        if (!found && (in_read[p] || in_write[p])) begin
          found   = 1'b1;
          m_busy  = 1'b1;
          m_owner = p;
          m_rd    = in_read[p];
          m_wr    = in_write[p];
          m_addr  = in_address[p];
          m_wdata = in_writedata[p];
          m_be    = in_byteenable[p];
        end
      end
    end else if (!mem_waitrequest) begin
      m_busy = 1'b0; m_rd = 1'b0; m_wr = 1'b0;
      m_rr   = (m_owner + 1) % PORTS;
    end
  endtask

  logic [PORTS-1:0] pend_rd, pend_wr, done;
  logic [PORTS-1:0] exp_w;
  logic [31:0]      tmp;

  initial begin
    rst_n = 1'b0; in_read = '0; in_write = '0; mem_waitrequest = 1'b1;
    mem_readdata = {16{8'hA5}};
    load_port_constants();

    // Directed table: single read, rr-ordered collision, reset during BUSY, re-assert after completion.
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b1111, 0, 0, -1));
    tbl.push_back(mk(1, 4'b0100, 4'b0000, 1, 4'b1111, 0, 0, -1));
    tbl.push_back(mk(1, 4'b0100, 4'b0000, 1, 4'b1111, 1, 0,  2));
    tbl.push_back(mk(1, 4'b0100, 4'b0000, 1, 4'b1111, 1, 0,  2));
    tbl.push_back(mk(1, 4'b0100, 4'b0000, 1, 4'b1111, 1, 0,  2));
    tbl.push_back(mk(1, 4'b0100, 4'b0000, 0, 4'b1011, 1, 0,  2));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 1, 4'b1111, 0, 0, -1));
    tbl.push_back(mk(1, 4'b0010, 4'b0000, 0, 4'b1111, 0, 0, -1));
    tbl.push_back(mk(1, 4'b0010, 4'b0000, 0, 4'b1101, 1, 0,  1));
    tbl.push_back(mk(1, 4'b1000, 4'b0010, 1, 4'b1111, 0, 0, -1));
    tbl.push_back(mk(1, 4'b1000, 4'b0010, 0, 4'b0111, 1, 0,  3));
    tbl.push_back(mk(1, 4'b0000, 4'b0010, 0, 4'b1111, 0, 0, -1));
    tbl.push_back(mk(1, 4'b0000, 4'b0010, 0, 4'b1101, 0, 1,  1));
    tbl.push_back(mk(1, 4'b0100, 4'b0000, 1, 4'b1111, 0, 0, -1));
    tbl.push_back(mk(1, 4'b0100, 4'b0000, 1, 4'b1111, 1, 0,  2));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 1, 4'b1111, 1, 0,  2));
    tbl.push_back(mk(1, 4'b0101, 4'b0000, 1, 4'b1111, 0, 0, -1));
    tbl.push_back(mk(1, 4'b0101, 4'b0000, 0, 4'b1110, 1, 0,  0));
    tbl.push_back(mk(1, 4'b0101, 4'b0000, 1, 4'b1111, 0, 0, -1));
    tbl.push_back(mk(1, 4'b0101, 4'b0000, 0, 4'b1011, 1, 0,  2));
    tbl.push_back(mk(1, 4'b0001, 4'b0000, 0, 4'b1111, 0, 0, -1));
    tbl.push_back(mk(1, 4'b0001, 4'b0000, 0, 4'b1110, 1, 0,  0));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 1, 4'b1111, 0, 0, -1));

    next_cycle();
    next_cycle();
    foreach (tbl[r]) begin
      rst_n = tbl[r].rst_n; in_read = tbl[r].rd; in_write = tbl[r].wr;
      mem_waitrequest = tbl[r].mw;
      #1;
      check($sformatf("row%0d in_waitrequest", r), 128'(in_waitrequest), 128'(tbl[r].e_wait));
      check($sformatf("row%0d mem_read", r), 128'(mem_read), 128'(tbl[r].e_rd));
      check($sformatf("row%0d mem_write", r), 128'(mem_write), 128'(tbl[r].e_wr));
      check($sformatf("row%0d in_readdata", r), in_readdata, {16{8'hA5}});
      if (tbl[r].e_port >= 0) begin
        check($sformatf("row%0d mem_address", r), 128'(mem_address), 128'(c_addr[tbl[r].e_port]));
        check($sformatf("row%0d mem_writedata", r), mem_writedata, c_wdata[tbl[r].e_port]);
        check($sformatf("row%0d mem_byteenable", r), 128'(mem_byteenable), 128'(c_be[tbl[r].e_port]));
      end
      next_cycle();
    end

    // All ports request continuously with single-cycle memory: grants go 0,1,2,3,0 every 2 cycles.
    rst_n = 1'b0; in_read = '0; in_write = '0; mem_waitrequest = 1'b0;
    next_cycle();
    rst_n = 1'b1; in_read = '1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (c % 2 == 1) begin
        exp_w = '1;
        exp_w[((c - 1) / 2) % PORTS] = 1'b0;
      end else begin
        exp_w = '1;
      end
      check($sformatf("rr c%0d in_waitrequest", c), 128'(in_waitrequest), 128'(exp_w));
      check($sformatf("rr c%0d mem_read", c), 128'(mem_read), 128'(c % 2 == 1));
      next_cycle();
    end

    // Randomized traffic against the reference model.
    rst_n = 1'b0; in_read = '0; in_write = '0; pend_rd = '0; pend_wr = '0; done = '0;
    #1;
    model_step();
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      for (int i = 0; i < PORTS; i++) begin
        if (done[i]) begin
          pend_rd[i] = 1'b0; pend_wr[i] = 1'b0;
        end
        if (!pend_rd[i] && !pend_wr[i] && $urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 1) == 0) pend_rd[i] = 1'b1;
          else                           pend_wr[i] = 1'b1;
          tmp = $urandom();
          in_address[i]    = {tmp[31:4], 4'h0};
          in_writedata[i]  = {$urandom(), $urandom(), $urandom(), $urandom()};
          tmp = $urandom();
          in_byteenable[i] = tmp[15:0];
        end
      end
      in_read = pend_rd; in_write = pend_wr;
      rst_n = ($urandom_range(0, 149) != 0);
      mem_waitrequest = ($urandom_range(0, 2) == 0);
      mem_readdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      #1;
      exp_w = model_wait();
      check($sformatf("rand c%0d in_waitrequest", c), 128'(in_waitrequest), 128'(exp_w));
      check($sformatf("rand c%0d mem_read", c), 128'(mem_read), 128'(m_rd));
      check($sformatf("rand c%0d mem_write", c), 128'(mem_write), 128'(m_wr));
      check($sformatf("rand c%0d in_readdata", c), in_readdata, mem_readdata);
      if (m_rd || m_wr) begin
        check($sformatf("rand c%0d mem_address", c), 128'(mem_address), 128'(m_addr));
        check($sformatf("rand c%0d mem_writedata", c), mem_writedata, m_wdata);
        check($sformatf("rand c%0d mem_byteenable", c), 128'(mem_byteenable), 128'(m_be));
      end
      done = ~exp_w;
      model_step();
    end

`ifdef CACHE_ARB_PERF_EN
    // Port 1 loses to port 0 for 4 cycles, then port 0 completes 5 transactions.
    load_port_constants();
    next_cycle();
    rst_n = 1'b0; in_read = '0; in_write = '0; mem_waitrequest = 1'b1;
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 14; c++) begin
      in_read         = (c < 4) ? 4'b0011 : (c < 13) ? 4'b0001 : 4'b0000;
      mem_waitrequest = (c < 4 || c == 13);
      next_cycle();
    end
    check("perf_grants[0]", 128'(perf_grants[0]), 128'(5));
    check("perf_wait_cycles[1]", 128'(perf_wait_cycles[1]), 128'(4));
    check("perf_wait_cycles[0]", 128'(perf_wait_cycles[0]), 128'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
